grayscale: RTL and testbench

- Upstream neighbour of the Sobel edge stage.
- Pops 24-bit RGB pixels from a first-word-fall-through input FIFO, converts each to 8-bit gray through a 2-stage registered pipeline, and pushes the result into the gray FIFO that the Sobel stage drains.
- Counts pixels per frame and pulses done after the last gray pixel of a frame is written.

---
 rtl/grayscale.sv | 147 ++++++++++++++
 tb/tb_grayscale.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grayscale.sv
// grayscale: RGB-to-gray conversion stage feeding the Sobel edge stage.
// Pops 24-bit RGB pixels from a first-word-fall-through FIFO, converts each
// one to an 8-bit gray value through a two-stage registered pipeline and
// pushes the result into the gray FIFO. It counts pixels per frame and pulses
// done for one cycle after the last gray pixel of a frame has been written.
//
// Optional feature macro: GRAYSCALE_LUMA_EN
//   undefined : gray = floor((R+G+B)/3)
//   defined   : gray = (77*R + 150*G + 29*B) >> 8
// Latency, handshake and frame counting are identical in both builds.
module grayscale #(
    parameter int IMG_HEIGHT = 540,
    parameter int IMG_WIDTH  = 720
) (
    input  logic        clock,
    input  logic        reset,
    output logic        in_rd_en,
    input  logic        in_empty,
    input  logic [23:0] in_dout,
    output logic        gray_wr_en,
    input  logic        gray_full,
    output logic [7:0]  gray_din,
    output logic        done
);

    localparam int TOTAL_PIXELS = IMG_HEIGHT * IMG_WIDTH;
    localparam int CNT_W        = $clog2(TOTAL_PIXELS + 1);
    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL_PIXELS);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL_PIXELS - 1);

`ifdef GRAYSCALE_LUMA_EN
    localparam int A_W = 16;
`else
    localparam int A_W = 10;
`endif

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;
    logic             a_valid_q, a_valid_d;
    logic [A_W-1:0]   a_data_q, a_data_d;
    logic             b_valid_q, b_valid_d;
    logic [7:0]       b_data_q, b_data_d;

    logic             advance;
    logic [A_W-1:0]   a_calc;
    logic [7:0]       gray_calc;
    logic [7:0]       pix_r, pix_g, pix_b;

    assign pix_r = in_dout[23:16];
    assign pix_g = in_dout[15:8];
    assign pix_b = in_dout[7:0];

    // Arithmetic: stage A intermediate from the FIFO head, stage B byte from stage A.
    always_comb begin
`ifdef GRAYSCALE_LUMA_EN
        // Weights sum to 256, so the 16-bit sum cannot overflow.
        a_calc    = 16'd77 * 16'(pix_r) + 16'd150 * 16'(pix_g) + 16'd29 * 16'(pix_b);
        gray_calc = a_data_q[15:8];
`else
        // Max sum is 765, so the quotient always fits in a byte.
        a_calc    = 10'(pix_r) + 10'(pix_g) + 10'(pix_b);
        gray_calc = 8'(a_data_q / 10'd3);
`endif
    end

    // Handshake: the whole pipeline moves unless a valid output is blocked by a full FIFO.
    // Strobes are forced low while reset is held so the FIFOs see no traffic.
    always_comb begin
        advance    = !b_valid_q || !gray_full;
        in_rd_en   = !reset && (state_q == S_RUN) && !in_empty && advance
                     && (rd_count_q < TOTAL_C);
        gray_wr_en = !reset && b_valid_q && !gray_full;
        gray_din   = b_valid_q ? b_data_q : 8'd0;
        done       = (state_q == S_DONE);
    end

    // Pipeline next state: on advance, A takes the popped pixel (or a bubble), B takes A.
    always_comb begin
        a_valid_d = a_valid_q;
        a_data_d  = a_data_q;
        b_valid_d = b_valid_q;
        b_data_d  = b_data_q;
        if (advance) begin
            a_valid_d = in_rd_en;
            a_data_d  = in_rd_en ? a_calc : '0;
            b_valid_d = a_valid_q;
            b_data_d  = a_valid_q ? gray_calc : 8'd0;
        end
    end

    // Frame FSM and counters: pops stop at the frame size, done follows the last write.
    always_comb begin
        state_d    = state_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        case (state_q)
            S_RUN: begin
                if (in_rd_en) begin
                    rd_count_d = rd_count_q + 1'b1;
                end
                if (gray_wr_en) begin
                    wr_count_d = wr_count_q + 1'b1;
                    if (wr_count_q == LAST_C) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Every popped pixel has been written, so the pipeline is already empty.
                rd_count_d = '0;
                wr_count_d = '0;
                state_d    = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // State register: reset discards any in-flight pixels and restarts the frame count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_RUN;
            rd_count_q <= '0;
            wr_count_q <= '0;
            a_valid_q  <= 1'b0;
            a_data_q   <= '0;
            b_valid_q  <= 1'b0;
            b_data_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            a_valid_q  <= a_valid_d;
            a_data_q   <= a_data_d;
            b_valid_q  <= b_valid_d;
            b_data_q   <= b_data_d;
        end
    end

endmodule

// File: tb/tb_grayscale.sv
// tb_grayscale: randomized bench for grayscale with a 4x3 frame (12 pixels).
// An input FIFO model feeds the DUT; every popped pixel is converted by a
// plain-arithmetic reference and queued, and every gray write is compared
// against the head of that queue. Frame accounting (12 pops, 12 writes, one
// done the cycle after the 12th write) is tracked independently of the DUT.
module tb_grayscale;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_empty;
    logic [23:0] in_dout;
    logic        gray_full;
    logic        in_rd_en;
    logic        gray_wr_en;
    logic [7:0]  gray_din;
    logic        done;

    grayscale #(.IMG_HEIGHT(H), .IMG_WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_rd_en   (in_rd_en),
        .in_empty   (in_empty),
        .in_dout    (in_dout),
        .gray_wr_en (gray_wr_en),
        .gray_full  (gray_full),
        .gray_din   (gray_din),
        .done       (done)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] fifo[$];
    int exp_q[$];
    int pop_cyc[$];

    int cyc = 0;
    int wr_model = 0;
    int pops_model = 0;
    int done_pending = 0;
    int done_obs = 0;
    int bubble_pct = 0;
    int strict_lat = 1;
    int full_ctrl = 0;
    int rst_ctrl = 1;
    int prev_full = 0;
    int prev_gray = 0;
    int last_gray = 0;
    int first_wr = 0;
    int last_wr = 0;

    function automatic int gray_ref(logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
`ifdef GRAYSCALE_LUMA_EN
        return (77 * r + 150 * g + 29 * b) / 256;
`else
        return (r + g + b) / 3;
`endif
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive on the falling edge, check 1 ns later, update the model at the rising edge.
    task automatic step();
        int take_done;
        int fin;
        int lat;
        @(negedge clock);
        reset     = rst_ctrl[0];
        gray_full = full_ctrl[0];
        in_empty  = (fifo.size() == 0) || ($urandom_range(99) < bubble_pct);
        in_dout   = (fifo.size() != 0) ? fifo[0] : 24'($urandom);
        #1;
        take_done = 0;
        fin       = 0;
        if (reset) begin
            check("rst_rd_en", int'(in_rd_en), 0);
            check("rst_wr_en", int'(gray_wr_en), 0);
            check("rst_gray_din", int'(gray_din), 0);
            check("rst_done", int'(done), 0);
        end else begin
            if (done) done_obs++;
            if (done_pending != 0) begin
                check("done", int'(done), 1);
                check("rd_at_done", int'(in_rd_en), 0);
                check("writes_per_frame", wr_model, N);
                take_done = 1;
            end else begin
                check("done_idle", int'(done), 0);
            end
            if (!gray_full)
                check("rd_en", int'(in_rd_en),
                      int'(!in_empty && pops_model < N && done_pending == 0));
            else if (gray_din != 8'd0)
                check("rd_stall", int'(in_rd_en), 0);
            if (prev_full != 0 && gray_full && prev_gray != 0)
                check("hold", int'(gray_din), prev_gray);
            if (gray_wr_en) begin
                if (exp_q.size() == 0) begin
                    check("spurious_wr", 1, 0);
                end else begin
                    check("gray_din", int'(gray_din), exp_q.pop_front());
                    lat = cyc - pop_cyc.pop_front();
                    if (strict_lat != 0) check("latency", lat, 2);
                    else check("latency_min", int'(lat >= 2), 1);
                end
                wr_model++;
                last_gray = int'(gray_din);
                if (wr_model == 1) first_wr = cyc;
                last_wr = cyc;
                fin = int'(wr_model == N);
            end
            if (in_rd_en) begin
                if (fifo.size() == 0 || in_empty) begin
                    check("pop_empty", 1, 0);
                end else begin
                    exp_q.push_back(gray_ref(fifo.pop_front()));
                    pop_cyc.push_back(cyc);
                    pops_model++;
                end
            end
        end
        prev_full = int'(gray_full);
        prev_gray = int'(gray_din);
        @(posedge clock);
        if (reset) begin
            exp_q.delete();
            pop_cyc.delete();
            wr_model     = 0;
            pops_model   = 0;
            done_pending = 0;
        end else begin
            if (take_done != 0) begin
                wr_model     = 0;
                pops_model   = 0;
                done_pending = 0;
            end
            if (fin != 0) done_pending = 1;
        end
        cyc++;
    endtask

    task automatic run_until_wr(input int n, input string tag);
        int budget;
        budget = 200;
        while (wr_model < n && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check({tag, "_timeout"}, wr_model, n);
    endtask

    task automatic run_until_done(input string tag);
        int d0;
        int budget;
        d0     = done_obs;
        budget = 300;
        while (done_obs == d0 && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check({tag, "_timeout"}, done_obs - d0, 1);
    endtask

    initial begin
        int d0;
        reset     = 1'b1;
        in_empty  = 1'b1;
        in_dout   = 24'h0;
        gray_full = 1'b0;

        // Reset state.
        rst_ctrl = 1;
        step();
        step();
        rst_ctrl = 0;
        step();

        // Single pixel with both FIFOs free: exact value and 2-cycle latency.
        fifo.push_back(24'hFF8040);
        run_until_wr(1, "single");
`ifdef GRAYSCALE_LUMA_EN
        check("px_ff8040", last_gray, 158);
`else
        check("px_ff8040", last_gray, 149);
`endif

        // Corner values.
        fifo.push_back(24'h000000);
        run_until_wr(2, "black");
        check("px_black", last_gray, 0);
        fifo.push_back(24'hFFFFFF);
        run_until_wr(3, "white");
        check("px_white", last_gray, 255);

        // Reset after 5 writes with more pixels in flight.
        for (int i = 0; i < 6; i++) fifo.push_back(24'($urandom));
        run_until_wr(5, "pre_reset");
        fifo.delete();
        rst_ctrl = 1;
        step();
        step();
        rst_ctrl = 0;

        // Full frame back-to-back plus a 13th pixel that must wait for done.
        d0 = done_obs;
        for (int i = 0; i < N + 1; i++) fifo.push_back(24'($urandom));
        run_until_done("frame1");
        check("frame1_span", last_wr - first_wr, N - 1);
        run_until_wr(1, "pix13");
        for (int i = 0; i < 4; i++) step();
        check("frame1_done_count", done_obs - d0, 1);

        // Back-pressure: gray FIFO full for 5 cycles mid-frame.
        strict_lat = 0;
        d0 = done_obs;
        for (int i = 0; i < N - 1; i++) fifo.push_back(24'($urandom) | 24'h100000);
        for (int i = 0; i < 4; i++) step();
        full_ctrl = 1;
        for (int i = 0; i < 5; i++) step();
        full_ctrl = 0;
        run_until_done("frame2");
        for (int i = 0; i < 4; i++) step();
        check("frame2_done_count", done_obs - d0, 1);
        strict_lat = 1;

        // Random input bubbles.
        bubble_pct = 30;
        d0 = done_obs;
        for (int i = 0; i < N; i++) fifo.push_back(24'($urandom));
        run_until_done("frame3");
        for (int i = 0; i < 4; i++) step();
        check("frame3_done_count", done_obs - d0, 1);
        bubble_pct = 0;

        check("drained_exp", exp_q.size(), 0);
        check("drained_fifo", fifo.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
